mem_master: RTL
===============

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter ADDR_W, default 8, address bus width.
REQ-002 Parameter DATA_W, default 8, data bus width.
REQ-003 Parameter WAIT_CYCLES, default 1, RAM access cycles, legal range 1..15.
REQ-004 clk  input  1  single system clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  transaction request, level-sampled in IDLE only.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr_in  input  ADDR_W  transaction address; sampled with req.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  last read result.
REQ-013 mem_addr  output  ADDR_W  RAM address.
REQ-014 mem_data  inout  DATA_W  shared bidirectional RAM data bus.
REQ-015 mem_rwn  output  1  RAM read/write-not: 1 = read, 0 = write.
REQ-016 mem_en  output  1  RAM enable, active-high.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, HOLD.
REQ-018 IDLE: if req=1 at a clk edge, latch we/addr_in/wdata and go to SETUP; otherwise stay.
REQ-019 SETUP: one cycle; mem_en=1, mem_addr=latched address, mem_rwn=~we_latched; load wait counter with WAIT_CYCLES; go to ACCESS.
REQ-020 ACCESS: exactly WAIT_CYCLES cycles; outputs held as in SETUP; counter decrements each edge; at count 1, go to HOLD.
REQ-021 Read: rdata SHALL capture mem_data on the edge leaving ACCESS; rdata holds until the next read capture.
REQ-022 HOLD: one cycle; done=1, mem_en=0, mem_rwn=1, bus released; go to IDLE.
REQ-023 Master SHALL drive mem_data only in SETUP/ACCESS of a write; all other times mem_data is high-Z.
REQ-024 Master SHALL never drive mem_data while mem_rwn=1.
REQ-025 mem_rwn SHALL be 1 in IDLE and HOLD and for the whole of a read.
REQ-026 Latency: done asserted in cycle WAIT_CYCLES+2 after the accepting edge (cycle 3 for the default).
REQ-027 req while busy, including during HOLD: ignored, no queuing.
REQ-028 Earliest back-to-back request: accepted on the first edge in IDLE after done.
REQ-029 addr_in/wdata/we changes after acceptance SHALL NOT affect the transaction in flight.
REQ-030 mem_addr SHALL hold its last value in IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force: state=IDLE, busy=0, done=0, mem_en=0, mem_rwn=1, mem_data high-Z, rdata=0, mem_addr=0, counter=0.
REQ-032 Reset mid-write SHALL abort the transaction and release the bus in the same instant; no done pulse.
REQ-033 First request after reset deassertion is accepted on the first clk edge with rst_n=1.

Structure
REQ-034 Shared package mem_bus_pkg SHALL hold the state enum, the RWN_READ=1 / RWN_WRITE=0 constants and the default widths.
REQ-035 Tri-state control SHALL be one instance of the existing ino8bit buffer, enabled by the internal drive signal.
REQ-036 FSM, counter and latches SHALL live in mem_master; there are no other sub-modules.

Verification
REQ-037 Write 0x06 to 0xFF, then read 0xFF -> done after 3 cycles each; rdata=0x06; mem_rwn=0 only in SETUP/ACCESS of the write.
REQ-038 Write 0x08 to 0xFE, write 0x0A to 0xFD, read 0xFE -> rdata=0x08; read 0xFD -> rdata=0x0A.
REQ-039 req pulsed in SETUP, ACCESS and HOLD of a write -> only one transaction; done pulses exactly once.
REQ-040 rst_n low during ACCESS of a write of 0x04 -> mem_data=Z and mem_en=0 with no clk edge; no done; later read shows old contents.
REQ-041 WAIT_CYCLES=3, read 0x10 preloaded with 0x5A -> done in cycle 5 after acceptance; rdata=0x5A.
REQ-042 Bus-contention assertion every cycle: never (master drive=1 and mem_rwn=1); at least one X-free mem_data sample per read.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus master: FSM states, bus polarity
// constants and default widths.
package mem_bus_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 8;
   localparam int unsigned DATA_W_DEFAULT = 8;

   // Wide enough for the largest legal WAIT_CYCLES (15).
   localparam int unsigned WAIT_W = 4;

   localparam logic RWN_READ  = 1'b1;
   localparam logic RWN_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } state_t;

   // Bus direction for a transaction type.
   function automatic logic rwn_of(input logic is_write);
      return is_write ? RWN_WRITE : RWN_READ;
   endfunction

endpackage

// File: rtl/ino8bit.sv
// Tri-state pad buffer: drives the shared bus only while en is high and
// always returns the resolved bus value.
module ino8bit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             en,
   input  logic [WIDTH-1:0] to_pad,
   output logic [WIDTH-1:0] from_pad,
   inout  wire  [WIDTH-1:0] pad
);

   // Release the pad whenever the owner is not driving.
   assign pad      = en ? to_pad : {WIDTH{1'bz}};
   assign from_pad = pad;

endmodule

// File: rtl/mem_master.sv
// Single-transaction RAM bus master: SETUP / ACCESS (WAIT_CYCLES) / HOLD
// sequence with a shared bidirectional data bus. WAIT_CYCLES must be 1..15.
module mem_master
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W      = DATA_W_DEFAULT,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              mem_rwn,
   output logic              mem_en
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
   localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);

   state_t             state;
   logic [WAIT_W-1:0]  cnt;
   logic               we_l;
   logic [DATA_W-1:0]  wdata_l;
   logic               drive;
   logic [DATA_W-1:0]  bus_in;

   // The only driver this master places on the shared data bus.
   ino8bit #(
      .WIDTH (DATA_W)
   ) u_bus_buf (
      .en       (drive),
      .to_pad   (wdata_l),
      .from_pad (bus_in),
      .pad      (mem_data)
   );

   // Busy is a pure decode of the registered state.
   assign busy = (state != IDLE);

   // Transaction FSM with registered bus outputs; reset releases the bus at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         we_l     <= 1'b0;
         wdata_l  <= '0;
         drive    <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         mem_addr <= '0;
         mem_rwn  <= RWN_READ;
         mem_en   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (req) begin
                  // Capture everything now so later input changes cannot leak in.
                  we_l     <= we;
                  wdata_l  <= wdata;
                  mem_addr <= addr_in;
                  mem_en   <= 1'b1;
                  mem_rwn  <= rwn_of(we);
                  drive    <= we;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               cnt   <= WAIT_LOAD;
               state <= ACCESS;
            end
            ACCESS: begin
               if (cnt == CNT_ONE) begin
                  if (!we_l) begin
                     rdata <= bus_in;
                  end
                  cnt     <= '0;
                  drive   <= 1'b0;
                  mem_en  <= 1'b0;
                  mem_rwn <= RWN_READ;
                  done    <= 1'b1;
                  state   <= HOLD;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            HOLD: begin
               // Requests seen here are dropped, not queued.
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               drive   <= 1'b0;
               mem_en  <= 1'b0;
               mem_rwn <= RWN_READ;
               done    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
